// File: rtl/ifetch.sv
// Instruction fetch stage: presents insn/IP to the decoder and keeps a
// single-entry prefetch buffer filled through one outstanding memory read.
module ifetch #(
  parameter int iaddr_width = 10,
  parameter int idata_width = 16,
  parameter logic [iaddr_width-1:0] RESET_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [iaddr_width-1:0] ip_next,
  input  logic                   advance,
  output logic                   imem_req,
  output logic [iaddr_width-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [idata_width-1:0] imem_rdata,
  output logic [iaddr_width-1:0] IP,
  output logic [idata_width-1:0] insn,
  output logic                   insn_valid
);

  logic [iaddr_width-1:0] ip_q, ip_d;
  logic [idata_width-1:0] insn_q, insn_d;
  logic                   insn_valid_q, insn_valid_d;
  logic [iaddr_width-1:0] pf_addr_q, pf_addr_d;
  logic [idata_width-1:0] pf_data_q, pf_data_d;
  logic                   pf_valid_q, pf_valid_d;
  logic [iaddr_width-1:0] req_addr_q, req_addr_d;
  logic                   req_busy_q, req_busy_d;
  logic                   req_stale_q, req_stale_d;

  logic                   ack;
  logic                   adv;
  logic                   pf_hit;
  logic                   ack_hit;
  logic                   issue;
  logic [iaddr_width-1:0] issue_addr;

  assign ack        = imem_ack && req_busy_q;
  assign adv        = insn_valid_q && advance;
  assign pf_hit     = pf_valid_q && (pf_addr_q == ip_next);
  assign ack_hit    = ack && !req_stale_q && (req_addr_q == ip_next);
  assign issue      = !req_busy_q && (!insn_valid_q || !pf_valid_q);
  assign issue_addr = insn_valid_q ? ip_q + 1'b1 : ip_q;

  assign imem_req   = req_busy_q;
  assign imem_addr  = req_addr_q;
  assign IP         = ip_q;
  assign insn       = insn_q;
  assign insn_valid = insn_valid_q;

  // Next-state: issue, then ack delivery, then decoder advance overrides.
  always_comb begin
    ip_d         = ip_q;
    insn_d       = insn_q;
    insn_valid_d = insn_valid_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    pf_valid_d   = pf_valid_q;
    req_addr_d   = req_addr_q;
    req_busy_d   = req_busy_q;
    req_stale_d  = req_stale_q;

    if (issue) begin
      req_busy_d = 1'b1;
      req_addr_d = issue_addr;
    end

    if (ack) begin
      req_busy_d = 1'b0;
      if (req_stale_q) begin
        req_stale_d = 1'b0;
      end else if (!insn_valid_q && req_addr_q == ip_q) begin
        insn_d       = imem_rdata;
        insn_valid_d = 1'b1;
      end else begin
        pf_data_d  = imem_rdata;
        pf_addr_d  = req_addr_q;
        pf_valid_d = 1'b1;
      end
    end

    if (adv) begin
      ip_d = ip_next;
      if (pf_hit) begin
        insn_d       = pf_data_q;
        insn_valid_d = 1'b1;
        pf_valid_d   = 1'b0;
      end else if (ack_hit) begin
        insn_d       = imem_rdata;
        insn_valid_d = 1'b1;
        pf_valid_d   = 1'b0;
      end else begin
        insn_valid_d = 1'b0;
        pf_valid_d   = 1'b0;
        // A read launched for the old path is poisoned unless it
        // happens to be the new demand address.
        if (req_busy_q) begin
          if (!ack && req_addr_q != ip_next)
            req_stale_d = 1'b1;
        end else if (issue && issue_addr != ip_next) begin
          req_stale_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q         <= RESET_ADDR;
      insn_q       <= '0;
      insn_valid_q <= 1'b0;
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
      pf_valid_q   <= 1'b0;
      req_addr_q   <= '0;
      req_busy_q   <= 1'b0;
      req_stale_q  <= 1'b0;
    end else begin
      ip_q         <= ip_d;
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
      pf_addr_q    <= pf_addr_d;
      pf_data_q    <= pf_data_d;
      pf_valid_q   <= pf_valid_d;
      req_addr_q   <= req_addr_d;
      req_busy_q   <= req_busy_d;
      req_stale_q  <= req_stale_d;
    end
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameters (name, default, meaning): iaddr_width, 10, instruction address width; idata_width, 16, instruction word width; RESET_ADDR, 0, first fetch address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ip_next  input  iaddr_width  next-IP result from the next-IP mux; sampled only on advance.
REQ-005 advance  input  1  decoder consumes current insn this cycle; ignored when insn_valid=0.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  iaddr_width  read address; stable while imem_req=1.
REQ-008 imem_ack  input  1  one-cycle completion strobe; imem_rdata valid in same cycle.
REQ-009 imem_rdata  input  idata_width  read data.
REQ-010 IP  output  iaddr_width  address of presented insn.
REQ-011 insn  output  idata_width  instruction word to decoder.
REQ-012 insn_valid  output  1  insn/IP valid.

Function
REQ-013 Internal state: IP, insn, insn_valid, one-entry prefetch buffer (pf_addr, pf_data, pf_valid), one outstanding request (req_addr, req_busy, req_stale).
REQ-014 imem_req SHALL equal req_busy and imem_addr SHALL equal req_addr, both registered; at most one request outstanding.
REQ-015 Once asserted, imem_req SHALL stay high with imem_addr unchanged until the cycle imem_ack=1; req_busy clears at that edge.
REQ-016 imem_ack while req_busy=0 SHALL be ignored.
REQ-017 Issue, evaluated when req_busy=0 (registered state, so ≥1 idle cycle after each ack): insn_valid=0 -> request IP; else pf_valid=0 -> request IP+1 mod 2^iaddr_width; else no request.
REQ-018 Ack with req_stale=1 SHALL discard imem_rdata and clear req_stale.
REQ-019 Ack, non-stale, insn_valid=0, req_addr==IP: insn<=imem_rdata, insn_valid<=1.
REQ-020 Ack, non-stale, otherwise: pf_data<=imem_rdata, pf_addr<=req_addr, pf_valid<=1.
REQ-021 Advance (insn_valid && advance): IP<=ip_next in all cases.
REQ-022 Advance hit, pf_valid && pf_addr==ip_next: insn<=pf_data, pf_valid<=0, insn_valid stays 1 (zero-bubble sequential flow).
REQ-023 Advance hit in same cycle as a non-stale ack with req_addr==ip_next (no prefetch hit): insn<=imem_rdata, insn_valid stays 1.
REQ-024 Advance miss: insn_valid<=0, pf_valid<=0; if a request is outstanding, not acked this cycle, and req_addr!=ip_next, req_stale<=1; if req_addr==ip_next it SHALL complete as the demand fetch (REQ-019).
REQ-025 Redirect to IP+1 with prefetch present SHALL be a hit (no special case for branches).
REQ-026 IP+1 computation wraps modulo 2^iaddr_width (max address -> 0).
REQ-027 insn_valid SHALL never assert for data whose fetch address differs from IP.

Reset
REQ-028 rst_n=0 asynchronously forces: IP=RESET_ADDR, insn=0, insn_valid=0, pf_valid=0, pf_addr=0, pf_data=0, req_busy=0 (imem_req=0), req_addr=0, req_stale=0.
REQ-029 First rising edge after rst_n release SHALL assert imem_req with imem_addr=RESET_ADDR.
REQ-030 Reset mid-request SHALL abandon it; a late imem_ack after reset SHALL be ignored per REQ-016 unless a new request is outstanding.

Verification
REQ-031 Boot: release reset, ack 2 cycles after req with rdata=0x1234 -> insn_valid=1, IP=0, insn=0x1234 edge after ack; next request addr=1.
REQ-032 Sequential stream: memory returns data=addr^0xA5A5, always-ready ack, advance held 1, ip_next=IP+1 -> insn sequence 0xA5A5,0xA5A4,... IP 0,1,2 with no insn_valid drop when prefetch lands before advance.
REQ-033 Branch miss: IP=5, prefetch 6 valid, advance with ip_next=0x200 -> insn_valid=0, pf_valid=0, next request addr=0x200, insn_valid=1 IP=0x200 after its ack.
REQ-034 Stale discard: prefetch for 6 outstanding, advance with ip_next=0x40 -> ack for 6 (rdata 0xDEAD) discarded, then request 0x40; 0xDEAD never appears on insn.
REQ-035 Wrap: IP=0x3FF, advance ip_next=0x000 -> prefetch address 0x000 used as hit; next prefetch addr 0x001.
REQ-036 Handshake hold: ack withheld 10 cycles -> imem_req=1, imem_addr constant throughout; asynchronous rst_n pulse mid-wait -> imem_req=0 immediately, REQ-029 sequence repeats.
